// File: rtl/colour_mode_ctrl.sv
// colour_mode_ctrl: button-driven mode sequencer for the colour_change datapath.
// Buttons are synchronised and debounced, then turned into press pulses.
// Presses and auto-cycle events compute a target mode. That target is held
// pending and committed to o_mode only on a vsync rising edge, so a frame is
// never split between two modes.
module colour_mode_ctrl #(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned DEB_W       = 16,
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned AUTO_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        btn,
  input  logic              i_vid_vsync,
  output logic [MODE_W-1:0] o_mode,
  output logic              o_mode_upd,
  output logic              o_pending,
  output logic              o_auto
);

  localparam int unsigned FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(AUTO_FRAMES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_t;

  // Button synchroniser and debounce state
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q [4];
  logic [DEB_W-1:0] cnt_d [4];
  logic [3:0]       press_q;

  // Frame timing and auto-cycle state
  logic             vsync_q;
  logic             vs_edge;
  logic             auto_q;
  logic [FC_W-1:0]  fc_q;

  // Mode sequencing state
  state_t           state_q;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] pend_q;
  logic             upd_q;

  // Event decode
  logic              manual;
  logic              auto_next;
  logic              ev_any;
  logic [MODE_W-1:0] base;
  logic [MODE_W-1:0] target;
  logic [MODE_W-1:0] commit_val;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: accept a new level after DEB_CYCLES stable samples
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // Debounce registers and the registered press pulse on each debounced rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q   <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q   <= deb_d;
      press_q <= deb_d & ~deb_q;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // vsync history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= i_vid_vsync;
    end
  end

  assign vs_edge = i_vid_vsync & ~vsync_q;

  // Event priority and target mode; base follows the queued value when one exists
  always_comb begin
    manual     = |press_q[2:0];
    auto_next  = auto_q & vs_edge & (fc_q == FC_LAST) & ~manual;
    ev_any     = manual | auto_next;
    base       = (state_q == ST_PENDING) ? pend_q : mode_q;
    if (press_q[2]) begin
      target = '0;
    end else if (press_q[0] | auto_next) begin
      target = (base == MODE_LAST) ? '0 : base + MODE_W'(1);
    end else begin
      target = (base == '0) ? MODE_LAST : base - MODE_W'(1);
    end
    commit_val = ev_any ? target : pend_q;
  end

  // Auto-cycle enable and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q <= 1'b0;
      fc_q   <= '0;
    end else begin
      if (press_q[3]) begin
        auto_q <= ~auto_q;
      end
      if (press_q[3] | manual) begin
        fc_q <= '0;
      end else if (auto_q & vs_edge) begin
        fc_q <= (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
      end
    end
  end

  // Mode FSM: queue changes in IDLE, commit the queued value on a vsync edge.
  // In IDLE a same-cycle vsync edge is ignored, so the change waits one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      pend_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (ev_any) begin
            pend_q <= target;
            if (target != mode_q) begin
              state_q <= ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          pend_q <= commit_val;
          if (vs_edge) begin
            state_q <= ST_IDLE;
            if (commit_val != mode_q) begin
              mode_q <= commit_val;
              upd_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mode     = mode_q;
  assign o_mode_upd = upd_q;
  assign o_pending  = (state_q == ST_PENDING);
  assign o_auto     = auto_q;

endmodule
